// File: rtl/uart_arb.sv
// Round-robin arbiter letting N Avalon-MM masters share one UART slave; 1-cycle grant latency, one transfer per grant.
// Non-owners see waitrequest=1; the owner sees the slave's waitrequest, and a stall past TMO cycles aborts with m_err.
module uart_arb #(
  parameter int N   = 4,
  parameter int ADW = 32,
  parameter int TMO = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           m_read,
  input  logic [N-1:0]           m_write,
  input  logic [N*ADW-1:0]       m_writedata,
  output logic [ADW-1:0]         m_readdata,
  output logic [N-1:0]           m_waitrequest,
  output logic [N-1:0]           m_err,
  output logic                   s_read,
  output logic                   s_write,
  output logic [ADW-1:0]         s_writedata,
  input  logic [ADW-1:0]         s_readdata,
  input  logic                   s_waitrequest,
  output logic [$clog2(N)-1:0]   grant,
  output logic                   busy
);

  localparam int GW = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_d;
  logic [GW-1:0]  ptr, ptr_d, grant_d, pick;
  logic [15:0]    stall, stall_d;
  logic [N-1:0]   pend;
  logic           any, gsel, stall_hit, abort;

  assign pend      = m_read | m_write;
  assign gsel      = pend[grant];
  assign stall_hit = (stall == 16'(TMO - 1));
  assign abort     = (state == GRANT) && gsel && s_waitrequest && stall_hit;
  assign busy      = (state == GRANT);
  assign m_readdata = s_readdata;

  // Rotating search starting just after the last owner.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && pend[(int'(ptr) + k) % N]) begin
        any  = 1'b1;
        pick = GW'((int'(ptr) + k) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= GW'(N - 1);
      grant <= '0;
      stall <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      grant <= grant_d;
      stall <= stall_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    grant_d = grant;
    stall_d = stall;
    case (state)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          grant_d = pick;
          stall_d = '0;
        end
      end
      GRANT: begin
        // Leave on completion, on the owner dropping its request, or on timeout.
        if (!gsel || !s_waitrequest || stall_hit) begin
          state_d = IDLE;
          ptr_d   = grant;
        end else begin
          stall_d = stall + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_writedata   = m_writedata[int'(grant)*ADW +: ADW];
    m_waitrequest = '1;
    m_err         = '0;
    if (state == GRANT) begin
      s_read               = m_read[grant];
      s_write              = m_write[grant];
      m_waitrequest[grant] = s_waitrequest & ~abort;
      m_err[grant]         = abort;
    end
  end

endmodule

// File: tb/tb_uart_arb.sv
// Directed bench for uart_arb (N=4, ADW=32, TMO=8): arbitration order, stall, timeout, drop and async reset.
module tb_uart_arb;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    m_read = '0;
  logic [3:0]    m_write = '0;
  logic [127:0]  m_writedata = '0;
  logic [31:0]   m_readdata;
  logic [3:0]    m_waitrequest;
  logic [3:0]    m_err;
  logic          s_read, s_write;
  logic [31:0]   s_writedata;
  logic [31:0]   s_readdata = '0;
  logic          s_waitrequest = 1'b0;
  logic [1:0]    grant;
  logic          busy;

  int vec = 0;
  int err = 0;

  uart_arb #(.N(4), .ADW(32), .TMO(8)) dut (
    .clk(clk), .rst(rst),
    .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest), .m_err(m_err),
    .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m_read = '0; m_write = '0; s_waitrequest = 1'b0;
    rst = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_readdata = 32'hA5C3_0F96;
    @(negedge clk);
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (grant !== 2'd0) begin err++; $display("FAIL reset_grant got %0d want 0", grant); end
    vec++; if (m_waitrequest !== 4'hF) begin err++; $display("FAIL reset_wait got %b want 1111", m_waitrequest); end
    vec++; if (m_err !== 4'h0) begin err++; $display("FAIL reset_err got %b want 0000", m_err); end
    vec++; if ({s_read, s_write} !== 2'b00) begin err++; $display("FAIL reset_srw got %b want 00", {s_read, s_write}); end
    vec++; if (m_readdata !== 32'hA5C3_0F96) begin err++; $display("FAIL readdata_pass got %h want a5c30f96", m_readdata); end
    s_readdata = 32'h1234_5678;
    #1;
    vec++; if (m_readdata !== 32'h1234_5678) begin err++; $display("FAIL readdata_pass2 got %h want 12345678", m_readdata); end
  endtask

  // Masters 1 and 2 writing continuously alternate, each grant taking 2 cycles.
  task automatic test_pair_rr();
    logic [1:0] eg;
    logic [3:0] ew;
    do_reset();
    m_write = 4'b0110;
    s_waitrequest = 1'b0;
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 0) ? 2'd1 : 2'd2;
      ew = 4'hF; ew[eg] = 1'b0;
      cyc(); @(negedge clk);
      vec++; if (busy !== 1'b1 || grant !== eg) begin err++; $display("FAIL rr_grant k=%0d got busy=%b grant=%0d want busy=1 grant=%0d", k, busy, grant, eg); end
      vec++; if (m_waitrequest !== ew) begin err++; $display("FAIL rr_wait k=%0d got %b want %b", k, m_waitrequest, ew); end
      vec++; if (s_write !== 1'b1) begin err++; $display("FAIL rr_swrite k=%0d got %b want 1", k, s_write); end
      cyc(); @(negedge clk);
      vec++; if (busy !== 1'b0 || m_waitrequest !== 4'hF || s_write !== 1'b0) begin err++; $display("FAIL rr_idle k=%0d got busy=%b wait=%b swrite=%b want 0/1111/0", k, busy, m_waitrequest, s_write); end
    end
    m_write = '0;
  endtask

  task automatic test_all_four();
    logic [1:0]  eg;
    logic [3:0]  ew;
    logic [31:0] ed;
    do_reset();
    for (int i = 0; i < 4; i++) m_writedata[i*32 +: 32] = 32'hC0DE_0000 | 32'(i * 17 + 3);
    m_write = 4'hF;
    for (int k = 0; k < 5; k++) begin
      eg = 2'(k % 4);
      ew = 4'hF; ew[eg] = 1'b0;
      ed = 32'hC0DE_0000 | 32'(int'(eg) * 17 + 3);
      cyc(); @(negedge clk);
      vec++; if (busy !== 1'b1 || grant !== eg) begin err++; $display("FAIL all_grant k=%0d got busy=%b grant=%0d want 1/%0d", k, busy, grant, eg); end
      vec++; if (s_writedata !== ed || s_write !== 1'b1) begin err++; $display("FAIL all_wdata k=%0d got %h/%b want %h/1", k, s_writedata, s_write, ed); end
      vec++; if (m_waitrequest !== ew) begin err++; $display("FAIL all_wait k=%0d got %b want %b", k, m_waitrequest, ew); end
      cyc(); @(negedge clk);
      vec++; if (busy !== 1'b0) begin err++; $display("FAIL all_idle k=%0d got busy=%b want 0", k, busy); end
    end
    m_write = '0;
  endtask

  task automatic test_stall();
    logic ew;
    do_reset();
    m_writedata[2*32 +: 32] = 32'h0000_0055;
    m_write = 4'b0100;
    s_waitrequest = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      s_waitrequest = (c <= 5);
      ew = (c <= 5);
      @(negedge clk);
      vec++; if (m_waitrequest[2] !== ew || m_err !== 4'h0) begin err++; $display("FAIL stall_wait c=%0d got wait2=%b err=%b want %b/0000", c, m_waitrequest[2], m_err, ew); end
      if (c == 6) begin
        vec++; if (s_write !== 1'b1 || s_writedata !== 32'h55) begin err++; $display("FAIL stall_xfer got swrite=%b wdata=%h want 1/00000055", s_write, s_writedata); end
      end
    end
    cyc(); @(negedge clk);
    vec++; if (busy !== 1'b0 || m_waitrequest !== 4'hF) begin err++; $display("FAIL stall_done got busy=%b wait=%b want 0/1111", busy, m_waitrequest); end
    m_write = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    m_read = 4'b0110;
    s_waitrequest = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc(); @(negedge clk);
      if (c < 8) begin
        vec++; if (m_err !== 4'h0 || m_waitrequest !== 4'hF || grant !== 2'd1 || s_read !== 1'b1) begin err++; $display("FAIL tmo_stall c=%0d got err=%b wait=%b grant=%0d sread=%b want 0000/1111/1/1", c, m_err, m_waitrequest, grant, s_read); end
      end else begin
        vec++; if (m_err !== 4'b0010 || m_waitrequest !== 4'b1101 || s_read !== 1'b1) begin err++; $display("FAIL tmo_abort got err=%b wait=%b sread=%b want 0010/1101/1", m_err, m_waitrequest, s_read); end
      end
    end
    cyc(); @(negedge clk);
    vec++; if (busy !== 1'b0 || m_err !== 4'h0) begin err++; $display("FAIL tmo_idle got busy=%b err=%b want 0/0000", busy, m_err); end
    cyc(); @(negedge clk);
    vec++; if (busy !== 1'b1 || grant !== 2'd2) begin err++; $display("FAIL tmo_next got busy=%b grant=%0d want 1/2", busy, grant); end
  endtask

  task automatic test_drop();
    do_reset();
    m_read = 4'b0001;
    s_waitrequest = 1'b1;
    cyc();
    m_read = 4'b0000;
    @(negedge clk);
    vec++; if (busy !== 1'b1 || grant !== 2'd0 || m_err !== 4'h0) begin err++; $display("FAIL drop_owner got busy=%b grant=%0d err=%b want 1/0/0000", busy, grant, m_err); end
    cyc(); @(negedge clk);
    vec++; if (busy !== 1'b0 || m_err !== 4'h0) begin err++; $display("FAIL drop_idle got busy=%b err=%b want 0/0000", busy, m_err); end
    m_read = 4'b0011;
    cyc(); @(negedge clk);
    vec++; if (grant !== 2'd1) begin err++; $display("FAIL drop_next got grant=%0d want 1", grant); end
    m_read = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_write = 4'b1000;
    s_waitrequest = 1'b1;
    cyc(); cyc(); cyc();
    @(negedge clk);
    vec++; if (busy !== 1'b1 || grant !== 2'd3) begin err++; $display("FAIL rmid_pre got busy=%b grant=%0d want 1/3", busy, grant); end
    m_write = 4'b1011;
    #2 rst = 1'b0;
    #1;
    vec++; if (busy !== 1'b0 || grant !== 2'd0 || m_err !== 4'h0) begin err++; $display("FAIL rmid_async got busy=%b grant=%0d err=%b want 0/0/0000", busy, grant, m_err); end
    vec++; if (m_waitrequest !== 4'hF || {s_read, s_write} !== 2'b00) begin err++; $display("FAIL rmid_outs got wait=%b srw=%b want 1111/00", m_waitrequest, {s_read, s_write}); end
    cyc();
    rst = 1'b1;
    cyc(); @(negedge clk);
    vec++; if (busy !== 1'b1 || grant !== 2'd0) begin err++; $display("FAIL rmid_next got busy=%b grant=%0d want 1/0", busy, grant); end
    m_write = '0;
  endtask

  initial begin
    test_reset();
    test_pair_rr();
    test_all_four();
    test_stall();
    test_timeout();
    test_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_arb.md
UART_ARB -- requirements
Module: uart_arb

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning number of Avalon MM masters sharing one UART slave (legal 2..8).
REQ-002 The block SHALL have parameter ADW, default 32, meaning Avalon data width.
REQ-003 The block SHALL have parameter TMO, default 1024, meaning stall-timeout limit in clock cycles (legal 2..65535).
REQ-004 The block SHALL have port clk  input  1  the single clock.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port m_read  input  N  per-master read request.
REQ-007 The block SHALL have port m_write  input  N  per-master write request.
REQ-008 The block SHALL have port m_writedata  input  N*ADW  per-master write data, master i at bits [i*ADW +: ADW].
REQ-009 The block SHALL have port m_readdata  output  ADW  read data broadcast to all masters.
REQ-010 The block SHALL have port m_waitrequest  output  N  per-master waitrequest.
REQ-011 The block SHALL have port m_err  output  N  per-master one-cycle timeout-abort pulse.
REQ-012 The block SHALL have ports s_read, s_write  output  1 each, s_writedata  output  ADW, s_readdata  input  ADW, s_waitrequest  input  1, all on the UART-slave side.
REQ-013 The block SHALL have port grant  output  $clog2(N)  index of the owning master, and port busy  output  1  high while in GRANT.

Function
REQ-014 The FSM SHALL have two states: IDLE and GRANT.
REQ-015 Requester i SHALL be pending when m_read[i] | m_write[i].
REQ-016 In IDLE, with at least one requester pending, the FSM SHALL latch the first pending index searching ptr+1, ptr+2, ... modulo N into grant and enter GRANT on the next edge (1-cycle arbitration latency); with none pending it SHALL stay in IDLE.
REQ-017 In GRANT, s_read, s_write and s_writedata SHALL combinationally equal the granted master's signals.
REQ-018 In IDLE, s_read and s_write SHALL be 0.
REQ-019 m_readdata SHALL equal s_readdata combinationally at all times.
REQ-020 m_waitrequest[grant] SHALL equal s_waitrequest in GRANT; every other bit, and all bits in IDLE, SHALL be 1.
REQ-021 Completion SHALL occur when the state is GRANT, the granted master is pending, and s_waitrequest=0; the next edge SHALL set ptr<=grant and enter IDLE (one transfer per grant).
REQ-022 If the granted master deasserts both read and write before completion, the FSM SHALL return to IDLE next edge with ptr<=grant and no m_err.
REQ-023 A stall counter (16 bits) SHALL clear on entry to GRANT and increment each GRANT cycle with s_waitrequest=1.
REQ-024 When the stall counter equals TMO-1 while s_waitrequest=1, the block SHALL pulse m_err[grant] for 1 cycle, drive m_waitrequest[grant]=0 that cycle, and then enter IDLE with ptr<=grant.
REQ-025 During an abort cycle, s_read and s_write SHALL still follow the master (no glitch-masking); the abort is signalled only via m_err.
REQ-026 Requests arriving from non-granted masters during GRANT SHALL be held off (waitrequest=1) and served no earlier than the next IDLE cycle.
REQ-027 Minimum spacing between grants SHALL be one IDLE cycle; back-to-back throughput SHALL be at most one transfer per 2 cycles plus slave stall.

Reset
REQ-028 While rst=0: state=IDLE, ptr=N-1 (so master 0 has first priority), grant=0, busy=0, stall counter=0, m_err=0, m_waitrequest=all ones, s_read=s_write=0.
REQ-029 Assertion of rst mid-GRANT SHALL abort immediately with no m_err pulse; first arbitration after release SHALL again favour master 0.

Verification
REQ-030 After reset, m_write=4'b0110 held and s_waitrequest=0 -> grants are 1,2,1,2...; each completion takes 2 cycles; master 0 and 3 waitrequest stay 1.
REQ-031 All four masters write continuously with s_waitrequest=0 -> grant order 0,1,2,3,0; s_writedata equals the granted master's data in each GRANT cycle.
REQ-032 Master 2 writes 0x55 and s_waitrequest=1 for 5 cycles then 0 -> m_waitrequest[2] low exactly 1 cycle, coincident with s_write=1 and s_writedata=0x55.
REQ-033 TMO=8, master 1 reads, s_waitrequest stuck at 1 -> m_err[1] pulses on GRANT cycle 8, FSM IDLE next cycle, then master 2 (if pending) granted.
REQ-034 Master 3 granted, rst driven low for 1 cycle mid-stall -> outputs match REQ-028 asynchronously; no m_err; next grant goes to lowest pending index starting at 0.
